// File: rtl/clkgate_ctrl.sv
// Always-on controller for an ICG enable: opens the gate on request, reports
// a stable gated clock after a wake delay, and closes it after an idle timeout.
module clkgate_ctrl #(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int WCNT_W      = $clog2(WAKE_CYCLES + 1),
  parameter int ICNT_W      = $clog2(IDLE_CYCLES + 1)
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              REQ,
  input  logic              BUSY,
  input  logic              FORCE_ON,
  output logic              GATE_EN,
  output logic              ACK,
  output logic [1:0]        STATE,
  output logic [ICNT_W-1:0] IDLE_CNT
);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_WAKE  = 2'd1,
    S_ON    = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_CYCLES - 1);
  localparam logic [ICNT_W-1:0] IDLE_LAST = ICNT_W'(IDLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [ICNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                gate_en_q, gate_en_d;
  logic                ack_q, ack_d;
  logic                wake_req;
  logic                act;

  assign wake_req = REQ | FORCE_ON;
  assign act      = REQ | BUSY | FORCE_ON;

  // State register; enables and counters are all flops so outputs are glitch-free.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= S_OFF;
      wcnt_q     <= '0;
      idle_cnt_q <= '0;
      gate_en_q  <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      idle_cnt_q <= idle_cnt_d;
      gate_en_q  <= gate_en_d;
      ack_q      <= ack_d;
    end
  end

  // Next-state and counter updates.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      S_OFF: begin
        wcnt_d     = '0;
        idle_cnt_d = '0;
        if (wake_req) state_d = S_WAKE;
      end
      S_WAKE: begin
        if (wcnt_q == WAKE_LAST) begin
          state_d    = S_ON;
          idle_cnt_d = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_ON: begin
        if (act) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = S_DRAIN;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + ICNT_W'(1);
        end
      end
      S_DRAIN: begin
        idle_cnt_d = '0;
        state_d    = act ? S_ON : S_OFF;
      end
      default: state_d = S_OFF;
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    gate_en_d = (state_d != S_OFF);
    ack_d     = (state_d == S_ON);
  end

  assign GATE_EN  = gate_en_q;
  assign ACK      = ack_q;
  assign STATE    = state_q;
  assign IDLE_CNT = idle_cnt_q;

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Directed and randomized checks of clkgate_ctrl against an edge-counting
// reference model of the wake / idle / drain rules.
module tb_clkgate_ctrl;

  localparam int WAKE = 2;
  localparam int IDLE = 4;
  localparam int IW   = $clog2(IDLE + 1);
  localparam int EW   = 2 + 1 + 1 + IW;

  logic          CLK = 1'b0;
  logic          RN = 1'b0;
  logic          REQ = 1'b0;
  logic          BUSY = 1'b0;
  logic          FORCE_ON = 1'b0;
  logic          GATE_EN;
  logic          ACK;
  logic [1:0]    STATE;
  logic [IW-1:0] IDLE_CNT;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model: phase names follow the documented encoding.
  int m_phase = 0;   // 0 off, 1 wake, 2 on, 3 drain
  int m_edges = 0;   // edges since the controller left OFF
  int m_idle  = 0;   // length of the current idle run while on

  clkgate_ctrl #(.WAKE_CYCLES(WAKE), .IDLE_CYCLES(IDLE)) dut (
    .CLK      (CLK),
    .RN       (RN),
    .REQ      (REQ),
    .BUSY     (BUSY),
    .FORCE_ON (FORCE_ON),
    .GATE_EN  (GATE_EN),
    .ACK      (ACK),
    .STATE    (STATE),
    .IDLE_CNT (IDLE_CNT)
  );

  // Clock / reset block.
  always #5 CLK = ~CLK;

  function automatic void push_expected();
    logic [1:0]    st;
    logic [IW-1:0] ic;
    st = 2'(m_phase);
    ic = IW'(m_idle);
    exp_q.push_back({st, (m_phase != 0), (m_phase == 2), ic});
  endfunction

  function automatic void model_reset();
    m_phase = 0;
    m_edges = 0;
    m_idle  = 0;
    push_expected();
  endfunction

  function automatic void model_edge(input logic r, input logic b, input logic f);
    bit wake_req;
    bit act;
    wake_req = r | f;
    act      = r | b | f;
    if (!RN) begin
      model_reset();
      return;
    end
    if (m_phase == 0) begin
      if (wake_req) begin
        m_phase = 1;
        m_edges = 0;
      end
    end else if (m_phase == 1) begin
      m_edges++;
      if (m_edges == WAKE) begin
        m_phase = 2;
        m_idle  = 0;
      end
    end else if (m_phase == 2) begin
      if (act) m_idle = 0;
      else if (m_idle + 1 == IDLE) begin
        m_phase = 3;
        m_idle  = 0;
      end else m_idle++;
    end else begin
      m_phase = act ? 2 : 0;
    end
    push_expected();
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare DUT outputs against the oldest expected entry.
  task automatic check_outputs(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_state"}, 8'(STATE), 8'(e[EW-1 -: 2]));
    chk({tag, "_gate"}, 8'(GATE_EN), 8'(e[IW+1]));
    chk({tag, "_ack"}, 8'(ACK), 8'(e[IW]));
    chk({tag, "_idle"}, 8'(IDLE_CNT), 8'(e[IW-1:0]));
    chk({tag, "_ack_gate"}, 8'(ACK & ~GATE_EN), 8'd0);
  endtask

  // Driver: apply inputs, take one edge, advance the model, compare.
  task automatic step(input logic r, input logic b, input logic f, input string tag);
    REQ = r; BUSY = b; FORCE_ON = f;
    @(posedge CLK);
    #1;
    model_edge(r, b, f);
    check_outputs(tag);
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    // Reset held low with random inputs.
    RN = 1'b0;
    for (int i = 0; i < 8; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "reset_hold");
    RN = 1'b1;
    step(1'b0, 1'b0, 1'b0, "reset_release");

    // BUSY alone must not wake.
    step(1'b0, 1'b1, 1'b0, "busy_no_wake");

    // Wake latency, then hold REQ until ACK.
    step(1'b1, 1'b0, 1'b0, "wake_e0");
    chk("wake_e0_state", 8'(STATE), 8'd1);
    step(1'b1, 1'b0, 1'b0, "wake_e1");
    chk("wake_e1_ack", 8'(ACK), 8'd0);
    step(1'b1, 1'b0, 1'b0, "wake_e2");
    chk("wake_e2_state", 8'(STATE), 8'd2);

    // Idle timeout through DRAIN to OFF.
    idle_steps(3, "idle_run");
    chk("idle_run_cnt", 8'(IDLE_CNT), 8'd3);
    idle_steps(1, "idle_drain");
    chk("idle_drain_state", 8'(STATE), 8'd3);
    idle_steps(1, "idle_off");
    chk("idle_off_gate", 8'(GATE_EN), 8'd0);

    // Idle restart with a BUSY pulse at count 3.
    step(1'b1, 1'b0, 1'b0, "restart_wake");
    step(1'b1, 1'b0, 1'b0, "restart_wake");
    step(1'b1, 1'b0, 1'b0, "restart_wake");
    idle_steps(3, "restart_idle");
    step(1'b0, 1'b1, 1'b0, "restart_busy");
    chk("restart_busy_cnt", 8'(IDLE_CNT), 8'd0);
    idle_steps(3, "restart_more");
    chk("restart_still_on", 8'(STATE), 8'd2);
    idle_steps(1, "restart_drain");

    // Re-request during DRAIN returns straight to ON.
    step(1'b1, 1'b0, 1'b0, "drain_req");
    chk("drain_req_state", 8'(STATE), 8'd2);
    idle_steps(IDLE + 1, "drain_req_idle");

    // FORCE_ON wakes and holds ON.
    for (int i = 0; i < 110; i++) step(1'b0, 1'b0, 1'b1, "force_on");
    chk("force_on_state", 8'(STATE), 8'd2);
    idle_steps(IDLE + 1, "force_release");

    // REQ dropped during WAKE still completes, then idles out.
    step(1'b1, 1'b0, 1'b0, "abort_req");
    idle_steps(WAKE, "abort_wake");
    idle_steps(IDLE + 1, "abort_idle");
    chk("abort_off", 8'(STATE), 8'd0);

    // Asynchronous reset mid-ON drops outputs before the next edge.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "async_pre");
    #2;
    RN = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    step(1'b1, 1'b1, 1'b1, "async_hold");
    RN = 1'b1;

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      RN = ($urandom_range(0, 199) != 0);
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 29) == 0), "random");
    end
    RN = 1'b1;
    idle_steps(WAKE + IDLE + 2, "final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clkgate_ctrl.md
Name: clkgate_ctrl

Overview:
- Sequential controller that drives the enable of an integrated clock-gate feeding a clkbuf-driven local clock tree.
- It is the requester-facing side of the gated-clock interface: it takes activity requests from the domain, opens the gate, signals when the gated clock is stable, and closes the gate after a programmable idle period.
- It sits in the always-on domain next to the ICG/clkbuf pair.
- GATE_EN comes straight from a flop, so it is glitch-free.

Parameters:
- WAKE_CYCLES, 2: cycles GATE_EN must be high before ACK asserts. Legal range is 1 or more.
- IDLE_CYCLES, 16: consecutive idle cycles in ON before the gate closes. Legal range is 1 or more.
- WCNT_W, $clog2(WAKE_CYCLES+1): wake counter width.
- ICNT_W, $clog2(IDLE_CYCLES+1): idle counter width.

Ports:
- CLK, input, 1: free-running always-on clock. All flops are rising-edge.
- RN, input, 1: asynchronous active-low reset.
- REQ, input, 1: domain requests the clock. Held high until ACK is seen.
- BUSY, input, 1: domain still active; counts as activity in ON and DRAIN.
- FORCE_ON, input, 1: test/debug override; counts as activity in every state.
- GATE_EN, output, 1: registered enable to the ICG.
- ACK, output, 1: registered; the gated clock is stable and usable.
- STATE, output, 2: current state encoding, for observability.
- IDLE_CNT, output, ICNT_W: current idle count.

Behaviour:
- Clock and reset:
  - One clock, CLK.
  - Reset is asynchronous, active-low, on RN.
  - While RN=0: STATE=OFF (0), GATE_EN=0, ACK=0, IDLE_CNT=0, wake counter=0.
  - Release is synchronous to the next CLK edge; the first evaluation happens at the first rising edge with RN=1.
- Activity definitions:
  - wake_req = REQ | FORCE_ON.
  - act = REQ | BUSY | FORCE_ON.
- State encoding: OFF=0, WAKE=1, ON=2, DRAIN=3.
- OFF:
  - GATE_EN=0, ACK=0.
  - If wake_req is sampled at an edge: go to WAKE, set GATE_EN=1, clear the wake counter.
  - BUSY alone does not wake the controller.
- WAKE:
  - GATE_EN=1, ACK=0.
  - The wake counter increments each edge.
  - At the edge where wake counter == WAKE_CYCLES-1: go to ON, set ACK=1, clear IDLE_CNT.
  - Result: ACK rises exactly WAKE_CYCLES edges after the OFF->WAKE edge.
  - REQ deasserting during WAKE does not abort. The controller completes to ON and then idles out.
- ON:
  - GATE_EN=1, ACK=1.
  - act=1: IDLE_CNT clears to 0.
  - act=0: IDLE_CNT increments.
  - At the edge where act=0 and IDLE_CNT == IDLE_CYCLES-1: go to DRAIN, set ACK=0, clear IDLE_CNT.
  - IDLE_CNT never exceeds IDLE_CYCLES-1 in ON.
- DRAIN:
  - Lasts exactly one cycle. GATE_EN=1 and ACK=0, which gives the domain a final clock cycle after ACK falls.
  - act=1 at the next edge: return to ON with ACK=1, without a wake delay.
  - act=0 at the next edge: go to OFF with GATE_EN=0.
- Simultaneous events:
  - FORCE_ON holds the controller in ON indefinitely.
  - Asserting FORCE_ON in OFF behaves exactly like a REQ.
- Reset mid-operation: in any state, RN=0 forces GATE_EN=0 and ACK=0 immediately (asynchronous). There is no drain.
- Output registration:
  - GATE_EN and ACK are flop outputs, with no combinational path from any input.
  - GATE_EN changes only on a rising CLK edge.
- Invariant: ACK=1 implies GATE_EN=1.
- Width rule: counters are unsigned. Compare against the parameter minus 1, sized to the counter width.

Test Plan:
- Reset: hold RN=0 and toggle inputs randomly. Required: GATE_EN=0, ACK=0, STATE=0 throughout. RN=0 asserted asynchronously mid-ON must drop GATE_EN and ACK before the next CLK edge.
- Wake latency: WAKE_CYCLES=2; pulse REQ high before edge 0. Required:
  - STATE=1 and GATE_EN=1 after edge 0.
  - STATE=2 and ACK=1 after edge 2.
  - ACK=0 after edges 0 and 1.
- Idle timeout: IDLE_CYCLES=4; in ON drop REQ, BUSY and FORCE_ON. Required:
  - IDLE_CNT=1,2,3 on successive edges.
  - DRAIN with ACK=0 on the 4th idle edge.
  - OFF with GATE_EN=0 one edge later.
- Idle restart: IDLE_CYCLES=4; pulse BUSY for one cycle when IDLE_CNT=3. Required: IDLE_CNT returns to 0, the controller stays in ON, and a full 4 further idle cycles are needed to reach DRAIN.
- DRAIN re-request: assert REQ during the DRAIN cycle. Required: STATE=2 and ACK=1 at the next edge, GATE_EN never drops, no WAKE state is visited.
- Override and abort:
  - FORCE_ON=1 from OFF: the controller wakes and stays in ON for 100 or more idle cycles.
  - REQ dropped during WAKE: the controller still reaches ON, then returns to OFF after IDLE_CYCLES+1 edges.
  - Checker: ACK=1 implies GATE_EN=1 on every cycle.
